// File: rtl/master_bus_arbiter_pkg.sv
// rtl/master_bus_arbiter_pkg.sv - arbitration policy/state types and index helper
package BusArb;

  typedef enum logic {
    ARB_FIXED       = 1'b0,
    ARB_ROUND_ROBIN = 1'b1
  } arb_mode_t;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_t;

  // Modulo-n increment of a port index
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/memory_bus_pkg.sv
// rtl/memory_bus_pkg.sv - memory bus command/result types shared by masters and slaves
package MemoryBus;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  byte_en;
    logic        mem_read;
    logic        mem_write;
  } Cmd;

  typedef struct packed {
    logic [31:0] read_data;
  } Result;

endpackage

// File: rtl/master_bus_arbiter_picker.sv
// rtl/master_bus_arbiter_picker.sv - combinational fixed/round-robin winner picker
module arb_picker
  import BusArb::*;
#(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] base_i,
  input  logic [IW-1:0] excl_i,
  input  logic          excl_en_i,
  input  arb_mode_t     mode_i,
  output logic [IW-1:0] winner_o,
  output logic          valid_o
);

  logic [N-1:0] cand;
  logic         found;
  int           j;

  // Mask out the excluded port, then scan either from index 0 or from base with wrap
  always_comb begin
    cand     = req_i;
    found    = 1'b0;
    j        = 0;
    winner_o = '0;
    if (excl_en_i) begin
      cand = req_i & ~({{(N-1){1'b0}}, 1'b1} << excl_i);
    end
    valid_o = |cand;
    if (mode_i == ARB_FIXED) begin
      // Descending scan so the lowest requesting index is the last written
      for (int i = N - 1; i >= 0; i--) begin
        if (cand[i]) begin
          winner_o = IW'(i);
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        j = int'(base_i) + k;
        if (j >= N) begin
          j = j - N;
        end
        if (!found && cand[j]) begin
          winner_o = IW'(j);
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/master_bus_arbiter.sv
// rtl/master_bus_arbiter.sv - N-master registered-grant arbiter onto one memory bus port
module master_bus_arbiter
  import BusArb::*;
#(
  parameter int        NUM_MASTERS = 3,
  parameter arb_mode_t MODE        = ARB_ROUND_ROBIN,
  parameter int        MAX_HOLD    = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  MemoryBus::Cmd    [NUM_MASTERS-1:0]   m_cmd,
  output MemoryBus::Result [NUM_MASTERS-1:0]   m_result,
  output logic             [NUM_MASTERS-1:0]   m_wait,
  output MemoryBus::Cmd                        s_cmd,
  input  MemoryBus::Result                     s_result,
  output logic             [NUM_MASTERS-1:0]   grant_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST    = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX_RST = IW'(NUM_MASTERS - 1);

  arb_state_t             state_q, state_d;
  logic [IW-1:0]          gnt_idx_q, gnt_idx_d;
  logic [IW-1:0]          last_idx_q, last_idx_d;
  logic [HW-1:0]          hold_cnt_q, hold_cnt_d;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] gnt_onehot;
  logic                   granted;
  logic                   holder_req;
  logic                   hold_expired;
  logic [IW-1:0]          pick_base;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;

  // A master requests whenever it asks for a read or a write
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      req[i] = m_cmd[i].mem_read | m_cmd[i].mem_write;
    end
  end

  // Decode current holder; while granted the picker always excludes the holder and
  // scans from just after it, which serves both release and forced rotation
  always_comb begin
    granted      = (state_q == ARB_GRANTED);
    gnt_onehot   = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << gnt_idx_q;
    holder_req   = |(req & gnt_onehot);
    hold_expired = (MAX_HOLD > 0) && (hold_cnt_q == HOLD_LAST);
    pick_base    = IW'(next_idx(granted ? int'(gnt_idx_q) : int'(last_idx_q), NUM_MASTERS));
  end

  arb_picker #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_picker (
    .req_i     (req),
    .base_i    (pick_base),
    .excl_i    (gnt_idx_q),
    .excl_en_i (granted),
    .mode_i    (MODE),
    .winner_o  (pick_idx),
    .valid_o   (pick_valid)
  );

  // Grant, release and hold-limit rotation decisions
  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    last_idx_d = last_idx_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d    = ARB_GRANTED;
          gnt_idx_d  = pick_idx;
          hold_cnt_d = '0;
        end
      end
      ARB_GRANTED: begin
        if (!holder_req) begin
          last_idx_d = gnt_idx_q;
          hold_cnt_d = '0;
          if (pick_valid) begin
            gnt_idx_d = pick_idx;
          end else begin
            state_d = ARB_IDLE;
          end
        end else if (hold_expired) begin
          // Without competitors the holder simply starts a fresh hold window
          hold_cnt_d = '0;
          if (pick_valid) begin
            last_idx_d = gnt_idx_q;
            gnt_idx_d  = pick_idx;
          end
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      gnt_idx_q  <= '0;
      last_idx_q <= LAST_IDX_RST;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_idx_q <= last_idx_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Route the holder onto the common bus and its result back; everyone else sees zero
  always_comb begin
    grant_o  = granted ? gnt_onehot : '0;
    s_cmd    = granted ? m_cmd[gnt_idx_q] : '0;
    m_result = '0;
    m_wait   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_wait[i] = req[i];
      if (granted && (gnt_idx_q == IW'(i))) begin
        m_result[i] = s_result;
        m_wait[i]   = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_master_bus_arbiter.sv
// tb/tb_master_bus_arbiter.sv - self-checking bench for master_bus_arbiter
module tb_master_bus_arbiter;
  import BusArb::*;

  typedef MemoryBus::Cmd    [2:0] cmd_vec_t;
  typedef MemoryBus::Result [2:0] res_vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  cmd_vec_t         cmd_a, cmd_b, cmd_c;
  res_vec_t         res_a, res_b, res_c;
  logic [2:0]       wait_a, wait_b, wait_c;
  logic [2:0]       grant_a, grant_b, grant_c;
  MemoryBus::Cmd    scmd_a, scmd_b, scmd_c;
  MemoryBus::Result s_res;

  int checks = 0;
  int errors = 0;

  // Reference model state for the two randomly driven instances: 0 = u_rr4, 1 = u_fx2
  int own  [2];
  int last [2];
  int held [2];

  master_bus_arbiter #(.NUM_MASTERS(3), .MODE(ARB_ROUND_ROBIN), .MAX_HOLD(4)) u_rr4 (
    .clk(clk), .rst(rst), .m_cmd(cmd_a), .m_result(res_a), .m_wait(wait_a),
    .s_cmd(scmd_a), .s_result(s_res), .grant_o(grant_a));

  master_bus_arbiter #(.NUM_MASTERS(3), .MODE(ARB_FIXED), .MAX_HOLD(0)) u_fx0 (
    .clk(clk), .rst(rst), .m_cmd(cmd_b), .m_result(res_b), .m_wait(wait_b),
    .s_cmd(scmd_b), .s_result(s_res), .grant_o(grant_b));

  master_bus_arbiter #(.NUM_MASTERS(3), .MODE(ARB_FIXED), .MAX_HOLD(2)) u_fx2 (
    .clk(clk), .rst(rst), .m_cmd(cmd_c), .m_result(res_c), .m_wait(wait_c),
    .s_cmd(scmd_c), .s_result(s_res), .grant_o(grant_c));

  function automatic MemoryBus::Cmd rand_cmd();
    MemoryBus::Cmd c;
    c.address    = $urandom;
    c.write_data = $urandom;
    c.byte_en    = 4'($urandom);
    c.mem_read   = 1'b0;
    c.mem_write  = 1'b0;
    if ($urandom_range(0, 1) == 1) c.mem_read = 1'b1;
    else c.mem_write = 1'b1;
    return c;
  endfunction

  function automatic logic [2:0] reqs(cmd_vec_t c);
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = c[i].mem_read | c[i].mem_write;
    return r;
  endfunction

  // Waiting masters hold their command; the owner may finish or issue another; idle ones may start
  function automatic cmd_vec_t next_stim(cmd_vec_t cur, int owner);
    cmd_vec_t n = cur;
    for (int i = 0; i < 3; i++) begin
      if (cur[i].mem_read | cur[i].mem_write) begin
        if (owner == i) begin
          if ($urandom_range(0, 3) == 0) n[i] = '0;
          else if ($urandom_range(0, 2) == 0) n[i] = rand_cmd();
        end
      end else if ($urandom_range(0, 2) == 0) begin
        n[i] = rand_cmd();
      end
    end
    return n;
  endfunction

  function automatic int model_pick(logic [2:0] r, int from_last, bit fixed);
    if (fixed) begin
      for (int i = 0; i < 3; i++) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= 3; k++) if (r[(from_last + k) % 3]) return (from_last + k) % 3;
    end
    return -1;
  endfunction

  // held counts granted cycles including the current one; at MAX_HOLD the turn ends if anyone waits
  task automatic model_step(int d, logic [2:0] r);
    bit         fixed = (d == 1);
    int         mh    = (d == 0) ? 4 : 2;
    logic [2:0] others;
    if (own[d] < 0) begin
      if (r != 0) begin
        own[d]  = model_pick(r, last[d], fixed);
        held[d] = 1;
      end
    end else if (!r[own[d]]) begin
      last[d] = own[d];
      own[d]  = model_pick(r, last[d], fixed);
      held[d] = 1;
    end else if (mh > 0 && held[d] >= mh) begin
      others = r & ~(3'b001 << own[d]);
      if (others != 0) begin
        last[d] = own[d];
        own[d]  = model_pick(others, last[d], fixed);
      end
      held[d] = 1;
    end else begin
      held[d] = held[d] + 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_c = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      own[d]  = -1;
      last[d] = 2;
      held[d] = 0;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_c = '0;
    s_res = 32'hdead_beef;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (grant_a !== 3'b000 || grant_b !== 3'b000 || grant_c !== 3'b000) begin
      errors++;
      $display("FAIL reset_grant: got %b %b %b expected 000", grant_a, grant_b, grant_c);
    end
    checks++;
    if (scmd_a !== '0) begin
      errors++;
      $display("FAIL reset_s_cmd: got %h expected 0", scmd_a);
    end
    checks++;
    if (res_a !== '0) begin
      errors++;
      $display("FAIL reset_result: got %h expected 0", res_a);
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (grant_a !== 3'b000 || wait_a !== 3'b000 || scmd_a !== '0) begin
        errors++;
        $display("FAIL idle_after_reset: grant %b wait %b s_cmd %h expected all zero", grant_a, wait_a, scmd_a);
      end
    end
  endtask

  task automatic test_single_read();
    MemoryBus::Cmd c;
    @(negedge clk);
    c = rand_cmd();
    c.address   = 32'h10;
    c.mem_read  = 1'b1;
    c.mem_write = 1'b0;
    cmd_a[1] = c;
    s_res    = 32'h1234_5678;
    #1;
    checks++;
    if (wait_a !== 3'b010 || grant_a !== 3'b000) begin
      errors++;
      $display("FAIL single_first_cycle: wait %b grant %b expected 010 000", wait_a, grant_a);
    end
    @(negedge clk);
    #1;
    checks++;
    if (grant_a !== 3'b010) begin
      errors++;
      $display("FAIL single_grant: got %b expected 010", grant_a);
    end
    checks++;
    if (scmd_a.address !== 32'h10 || scmd_a.mem_read !== 1'b1) begin
      errors++;
      $display("FAIL single_s_cmd: addr %h rd %b expected 10 1", scmd_a.address, scmd_a.mem_read);
    end
    checks++;
    if (res_a[1].read_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL single_result1: got %h expected 12345678", res_a[1].read_data);
    end
    checks++;
    if (res_a[0].read_data !== 32'h0 || res_a[2].read_data !== 32'h0) begin
      errors++;
      $display("FAIL single_other_results: got %h %h expected 0 0", res_a[0].read_data, res_a[2].read_data);
    end
    checks++;
    if (wait_a !== 3'b000) begin
      errors++;
      $display("FAIL single_wait_granted: got %b expected 000", wait_a);
    end
    cmd_a[1] = '0;
    @(negedge clk);
    #1;
    checks++;
    if (grant_a !== 3'b000 || scmd_a !== '0) begin
      errors++;
      $display("FAIL single_release: grant %b s_cmd %h expected 000 0", grant_a, scmd_a);
    end
  endtask

  task automatic test_rr_rotation();
    logic [2:0] exp;
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) cmd_a[i] = rand_cmd();
    #1;
    checks++;
    if (wait_a !== 3'b111 || grant_a !== 3'b000) begin
      errors++;
      $display("FAIL rr_first_cycle: wait %b grant %b expected 111 000", wait_a, grant_a);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      #1;
      exp = 3'b001 << ((k / 4) % 3);
      checks++;
      if (grant_a !== exp) begin
        errors++;
        $display("FAIL rr_sequence cycle %0d: got %b expected %b", k, grant_a, exp);
      end
      checks++;
      if (scmd_a !== cmd_a[(k / 4) % 3]) begin
        errors++;
        $display("FAIL rr_s_cmd cycle %0d: got %h expected %h", k, scmd_a, cmd_a[(k / 4) % 3]);
      end
    end
    cmd_a = '0;
  endtask

  task automatic test_fixed_hold();
    do_reset();
    @(negedge clk);
    cmd_b[0] = rand_cmd();
    cmd_b[2] = rand_cmd();
    #1;
    checks++;
    if (wait_b !== 3'b101) begin
      errors++;
      $display("FAIL fixed_first_cycle: wait %b expected 101", wait_b);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (grant_b !== 3'b001 || wait_b[2] !== 1'b1) begin
        errors++;
        $display("FAIL fixed_hold cycle %0d: grant %b wait2 %b expected 001 1", k, grant_b, wait_b[2]);
      end
    end
    cmd_b[0] = '0;
    #1;
    checks++;
    if (grant_b !== 3'b001 || scmd_b.mem_read !== 1'b0 || scmd_b.mem_write !== 1'b0) begin
      errors++;
      $display("FAIL fixed_release_cycle: grant %b rd %b wr %b expected 001 0 0", grant_b, scmd_b.mem_read, scmd_b.mem_write);
    end
    @(negedge clk);
    #1;
    checks++;
    if (grant_b !== 3'b100 || wait_b !== 3'b000) begin
      errors++;
      $display("FAIL fixed_handover: grant %b wait %b expected 100 000", grant_b, wait_b);
    end
    cmd_b = '0;
  endtask

  task automatic test_hold_restart();
    do_reset();
    @(negedge clk);
    cmd_c[2] = rand_cmd();
    #1;
    checks++;
    if (wait_c !== 3'b100 || grant_c !== 3'b000) begin
      errors++;
      $display("FAIL hold_first_cycle: wait %b grant %b expected 100 000", wait_c, grant_c);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (grant_c !== 3'b100 || wait_c !== 3'b000) begin
        errors++;
        $display("FAIL hold_restart cycle %0d: grant %b wait %b expected 100 000", k, grant_c, wait_c);
      end
    end
    cmd_c = '0;
  endtask

  task automatic test_async_reset();
    MemoryBus::Cmd c;
    do_reset();
    @(negedge clk);
    c = rand_cmd();
    c.mem_read  = 1'b0;
    c.mem_write = 1'b1;
    cmd_a[0] = c;
    @(negedge clk);
    #1;
    checks++;
    if (grant_a !== 3'b001 || scmd_a.mem_write !== 1'b1) begin
      errors++;
      $display("FAIL async_pre_grant: grant %b wr %b expected 001 1", grant_a, scmd_a.mem_write);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (grant_a !== 3'b000 || scmd_a.mem_write !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_immediate: grant %b wr %b expected 000 0", grant_a, scmd_a.mem_write);
    end
    for (int i = 0; i < 3; i++) cmd_a[i] = rand_cmd();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (wait_a !== 3'b111 || grant_a !== 3'b000) begin
      errors++;
      $display("FAIL async_release_wait: wait %b grant %b expected 111 000", wait_a, grant_a);
    end
    @(negedge clk);
    #1;
    checks++;
    if (grant_a !== 3'b001) begin
      errors++;
      $display("FAIL async_first_winner: got %b expected 001", grant_a);
    end
    cmd_a = '0;
  endtask

  task automatic test_random();
    cmd_vec_t         c;
    logic [2:0]       g, w, r, exp_g, exp_w;
    MemoryBus::Cmd    sc, exp_sc;
    res_vec_t         rs;
    logic [31:0]      exp_rd;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      cmd_a = next_stim(cmd_a, own[0]);
      cmd_c = next_stim(cmd_c, own[1]);
      s_res = $urandom;
      #1;
      for (int d = 0; d < 2; d++) begin
        c  = (d == 0) ? cmd_a   : cmd_c;
        g  = (d == 0) ? grant_a : grant_c;
        w  = (d == 0) ? wait_a  : wait_c;
        sc = (d == 0) ? scmd_a  : scmd_c;
        rs = (d == 0) ? res_a   : res_c;
        r  = reqs(c);
        exp_g  = (own[d] < 0) ? 3'b000 : (3'b001 << own[d]);
        exp_w  = r & ~exp_g;
        exp_sc = (own[d] < 0) ? '0 : c[own[d]];
        checks++;
        if (g !== exp_g) begin
          errors++;
          $display("FAIL rand_grant dut%0d cycle %0d: got %b expected %b", d, cyc, g, exp_g);
        end
        checks++;
        if (w !== exp_w) begin
          errors++;
          $display("FAIL rand_wait dut%0d cycle %0d: got %b expected %b", d, cyc, w, exp_w);
        end
        checks++;
        if (sc !== exp_sc) begin
          errors++;
          $display("FAIL rand_s_cmd dut%0d cycle %0d: got %h expected %h", d, cyc, sc, exp_sc);
        end
        for (int i = 0; i < 3; i++) begin
          exp_rd = (own[d] == i) ? s_res.read_data : 32'h0;
          checks++;
          if (rs[i].read_data !== exp_rd) begin
            errors++;
            $display("FAIL rand_result dut%0d m%0d cycle %0d: got %h expected %h", d, i, cyc, rs[i].read_data, exp_rd);
          end
        end
      end
      @(posedge clk);
      model_step(0, reqs(cmd_a));
      model_step(1, reqs(cmd_c));
    end
    cmd_a = '0;
    cmd_c = '0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_rr_rotation();
    test_fixed_hold();
    test_hold_restart();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/master_bus_arbiter.md
Name: master_bus_arbiter

Overview:
- N-master successor to the two-input master bus mux, which selects by a static select line.
- Arbitrates NUM_MASTERS MemoryBus::Cmd masters (CPU data port, debug probe, future DMA) onto one common MemoryBus port feeding the slave bus mux.
- Grant is registered, with per-master wait back-pressure.
- Selectable fixed-priority or round-robin policy, plus an optional hold limit that forces rotation.

Parameters:
- NUM_MASTERS, 3, number of master ports (2..8).
- MODE, ARB_ROUND_ROBIN, arbitration policy: ARB_FIXED (lowest index wins) or ARB_ROUND_ROBIN.
- MAX_HOLD, 16, maximum consecutive grant cycles per master while others request; 0 means unlimited.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- m_cmd  in  MemoryBus::Cmd x NUM_MASTERS  per-master command.
- m_result  out  MemoryBus::Result x NUM_MASTERS  per-master result.
- m_wait  out  NUM_MASTERS  1 = master requesting but not granted; it must hold its cmd stable.
- s_cmd  out  MemoryBus::Cmd  command to the common bus.
- s_result  in  MemoryBus::Result  result from the common bus.
- grant_o  out  NUM_MASTERS  one-hot current grant (all zero = bus idle).

Behaviour:
- Request: req[i] = m_cmd[i].mem_read | m_cmd[i].mem_write.
- State register: IDLE or GRANTED, plus gnt_idx, last_idx and hold_cnt.
- Reset (async, rst low):
  - state=IDLE, grant_o=0, gnt_idx=0, last_idx=NUM_MASTERS-1, hold_cnt=0.
  - s_cmd is all zero immediately.
  - m_result read_data is 0 for every master.
- IDLE:
  - If any req, the picker selects winner W; at the next edge state=GRANTED, gnt_idx=W, hold_cnt=0.
  - Grant latency is one cycle from first request.
- GRANTED:
  - s_cmd = m_cmd[gnt_idx] combinationally.
  - m_result[gnt_idx] = s_result; all other m_result read_data = 0.
- Release: if req[gnt_idx]=0 at an edge, last_idx=gnt_idx.
  - If other requests are present, re-pick the same edge; the new grant is active the next cycle.
  - Otherwise go to IDLE.
  - The release cycle itself drives s_cmd from the (now non-requesting) holder; this is harmless because mem_read=mem_write=0.
- Hold limit (MAX_HOLD>0):
  - hold_cnt increments each granted cycle.
  - When hold_cnt = MAX_HOLD-1 and another master requests, the grant is forcibly rotated at that edge: the picker excludes gnt_idx, and last_idx=gnt_idx.
  - If no other master requests, hold_cnt resets to 0 and the grant stays.
  - hold_cnt saturates; it never wraps into a false expiry.
- Picker, ARB_ROUND_ROBIN: first requester scanning from (last_idx+1) mod NUM_MASTERS upward, wrapping.
- Picker, ARB_FIXED: lowest-index requester, honouring the exclusion during forced rotation.
- m_wait[i] = req[i] & ~(state==GRANTED & gnt_idx==i), combinational.
  - A new requester therefore sees wait=1 for at least one cycle.
- Simultaneous release and new request by the same master at one edge: treated as continuous request, grant retained.
- Never more than one grant_o bit is set.
- Bus idle (IDLE): s_cmd is all zero.

Decomposition:
- Package BusArb holds:
  - arb_mode_t enum {ARB_FIXED, ARB_ROUND_ROBIN}.
  - arb_state_t enum {ARB_IDLE, ARB_GRANTED}.
  - Function next_idx(idx, n) for modulo increment.
- MemoryBus::Cmd and MemoryBus::Result are reused unchanged.
- One sub-module, arb_picker: combinational.
  - Inputs: req vector, base index, exclude index, exclude enable, mode.
  - Outputs: winner index and valid.
  - Reused later by the slave-side interrupt controller.

Test Plan:
- Reset release, no requests: grant_o=0, s_cmd all zero, m_wait=0.
- Master 1 alone reads address 'h10:
  - cycle t: m_wait[1]=1.
  - t+1: grant_o=3'b010, s_cmd.address='h10, m_result[1].read_data = s_result value.
  - m_result[0] and m_result[2] read_data = 0.
- ARB_ROUND_ROBIN, masters 0,1,2 requesting continuously, MAX_HOLD=4: grant sequence 0,1,2,0, each held exactly 4 cycles; never two grant bits set.
- ARB_FIXED, masters 0 and 2 requesting, MAX_HOLD=0: master 0 holds indefinitely, m_wait[2] stays 1; master 0 drops req -> grant_o=3'b100 next cycle.
- MAX_HOLD=2, only master 2 requesting for 10 cycles: grant never lost, hold_cnt restarts, no idle gap.
- rst asserted mid-write with grant_o=3'b001: s_cmd.mem_write=0 and grant_o=0 without waiting for a clock edge.
- After rst deasserts with all three requesting, round-robin grants master 0 first.
